// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // First byte of every frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Memory entries are byte-addressed, so one word covers four entries.
    function automatic int unsigned max_words(input int unsigned mem_entries);
        return mem_entries / 4;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction memory write port and core status out.
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1. The source holds in_data stable while in_valid is 1
// and in_ready is 0. in_ready is registered and only drops during a write
// cycle (wr_en=1).
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    state_e      dbg_state;

    // Loader side.
    modport master (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, dbg_state
    );

    // Stream source / memory / core side.
    modport slave (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, dbg_state
    );

endinterface

// File: rtl/imem_word_packer.sv
// Collects stream bytes LSB first and flags the byte that completes a word.
// word/word_done are valid in the same cycle as the completing byte strobe;
// the top level registers them into the memory write port.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_stb,
    input  logic [7:0]  byte_in,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  j_q, j_d;
    logic [23:0] sh_q, sh_d;

    // Byte slot counter and three-byte shift register, newest byte on top.
    always_comb begin
        j_d  = j_q;
        sh_d = sh_q;
        if (clear) begin
            j_d  = '0;
            sh_d = '0;
        end else if (byte_stb) begin
            j_d  = j_q + 2'd1;
            sh_d = {byte_in, sh_q[23:8]};
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            j_q  <= '0;
            sh_q <= '0;
        end else begin
            j_q  <= j_d;
            sh_q <= sh_d;
        end
    end

    assign word_done = byte_stb && !clear && (j_q == 2'd3);
    assign word      = {byte_in, sh_q};

endmodule

// File: rtl/imem_loader.sv
// Frame parser: SYNC, LEN, 4*LEN data bytes, XOR checksum. Writes each word
// to instruction memory and releases the core only after a clean frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_ENTRIES = 64,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.master  bus
);

    localparam int unsigned MAX_W = max_words(MEM_ENTRIES);
    localparam int          K_W   = $clog2(MAX_W + 1);
    localparam int          T_W   = $clog2(TIMEOUT_CYC + 1);

    state_e         state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [K_W-1:0] n_q, n_d;
    logic [K_W-1:0] k_inc;
    logic [7:0]     csum_q, csum_d;
    logic [T_W-1:0] tmo_q, tmo_d;
    logic           in_ready_q, in_ready_d;
    logic           wr_en_q, wr_en_d;
    logic [31:0]    wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           hold_q, hold_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic           accept;
    logic           is_sync;
    logic           frame_start;
    logic           byte_stb;
    logic           word_done;
    logic [31:0]    word;

    assign accept  = bus.in_valid && in_ready_q;
    assign is_sync = (bus.in_data == SYNC_BYTE);
    assign k_inc   = k_q + 1'b1;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .byte_stb  (byte_stb),
        .byte_in   (bus.in_data),
        .word_done (word_done),
        .word      (word)
    );

    // Next state, counters, checksum and registered outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        csum_d      = csum_q;
        tmo_d       = '0;
        in_ready_d  = 1'b1;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        hold_d      = hold_q;
        done_d      = done_q;
        error_d     = error_q;
        frame_start = 1'b0;
        byte_stb    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // Anything other than SYNC is dropped between frames.
                if (accept && is_sync) begin
                    state_d     = ST_LEN;
                    frame_start = 1'b1;
                    k_d         = '0;
                    n_d         = '0;
                    csum_d      = '0;
                    hold_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (bus.in_data == 8'd0 || {24'd0, bus.in_data} > MAX_W) begin
                        state_d = ST_ERR;
                        hold_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        n_d     = K_W'(bus.in_data);
                        k_d     = '0;
                        csum_d  = '0;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    byte_stb = 1'b1;
                    csum_d   = csum_q ^ bus.in_data;
                    if (word_done) begin
                        // Write cycle: no byte can be taken while wr_en is high.
                        wr_en_d    = 1'b1;
                        in_ready_d = 1'b0;
                        wr_addr_d  = {{(32-K_W-2){1'b0}}, k_q, 2'b00};
                        wr_data_d  = word;
                        k_d        = k_inc;
                        if (k_inc == n_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        state_d = ST_DONE;
                        hold_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        hold_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Inter-byte timeout, only while a frame is open.
        if (state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CSUM) begin
            if (!accept) begin
                if (tmo_q == T_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_ERR;
                    hold_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        end
    end

    // State and output registers; reset holds the core and drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: driver tasks feed framed byte streams, a frame
// model predicts memory writes and frame outcomes into queues, and a
// negedge monitor pops and compares whenever the DUT writes or reports.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int TMO = 1024;

    typedef struct packed {
        logic done;
        logic error;
        logic by_byte;
    } outcome_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_q[$];
    outcome_t    out_q[$];
    logic [31:0] fw[16];

    logic acc_last  = 1'b0;
    logic stat_prev = 1'b0;
    logic [63:0] mon_e;
    outcome_t    mon_o;

    imem_loader_if bus();

    imem_loader #(
        .MEM_ENTRIES (64),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte acceptance at the most recent rising edge.
    always @(posedge clk) begin
        acc_last = rst && bus.in_valid && bus.in_ready;
    end

    // Monitor: writes, ready behaviour and frame outcomes.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            check("in_ready_in_wr_cycle", {31'd0, bus.in_ready}, 32'd0);
            check("wr_latency", {31'd0, acc_last}, 32'd1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, mon_e[63:32]);
                check("wr_data", bus.wr_data, mon_e[31:0]);
            end
        end else begin
            check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        end
        if (rst && (bus.done || bus.error) && !stat_prev) begin
            if (out_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL outcome_unexpected: got done %b error %b expected none", bus.done, bus.error);
            end else begin
                mon_o = out_q.pop_front();
                check("outcome_done", {31'd0, bus.done}, {31'd0, mon_o.done});
                check("outcome_error", {31'd0, bus.error}, {31'd0, mon_o.error});
                check("outcome_hold", {31'd0, bus.cpu_hold}, {31'd0, ~mon_o.done});
                if (mon_o.by_byte) begin
                    check("outcome_latency", {31'd0, acc_last}, 32'd1);
                end
            end
        end
        stat_prev = bus.done || bus.error;
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte; returns at the negedge after it has been taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_stuck: got in_ready %b expected 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    // Frame model: words fw[0..len-1] land at byte address 4*i, checksum is
    // the XOR of every payload byte; bad length ends the frame after LEN.
    task automatic send_frame(input int len, input bit bad, input bit gaps, input bit skip_sync);
        logic [7:0] cs;
        logic [7:0] b;
        outcome_t   o;
        if (!skip_sync) send_byte(SYNC_BYTE, gaps);
        if (len == 0 || len > 16) begin
            o.done = 1'b0; o.error = 1'b1; o.by_byte = 1'b1;
            out_q.push_back(o);
            send_byte(8'(len), gaps);
            return;
        end
        send_byte(8'(len), gaps);
        cs = 8'd0;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < 4; j++) begin
                b  = fw[i][8*j +: 8];
                cs = cs ^ b;
                if (j == 3) exp_q.push_back({32'(4 * i), fw[i]});
                send_byte(b, gaps);
            end
        end
        if (bad) cs = cs ^ 8'h01;
        o.done = ~bad; o.error = bad; o.by_byte = 1'b1;
        out_q.push_back(o);
        send_byte(cs, gaps);
    endtask

    task automatic randomize_words();
        for (int i = 0; i < 16; i++) fw[i] = $urandom();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    // Stimulus.
    initial begin
        outcome_t o;
        logic [7:0] junk;
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(2);

        // Known-good two-word frame, checksum 0x70.
        fw[0] = 32'h00500013;
        fw[1] = 32'h00A00093;
        send_frame(2, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("good_done", {31'd0, bus.done}, 32'd1);
        check("good_hold", {31'd0, bus.cpu_hold}, 32'd0);

        // SYNC while loaded re-holds the core, then LEN times out.
        send_byte(SYNC_BYTE, 1'b0);
        check("resync_hold", {31'd0, bus.cpu_hold}, 32'd1);
        check("resync_done", {31'd0, bus.done}, 32'd0);
        o.done = 1'b0; o.error = 1'b1; o.by_byte = 1'b0;
        out_q.push_back(o);
        idle(TMO + 8);
        check("len_timeout_error", {31'd0, bus.error}, 32'd1);

        // Same frame, checksum 0x71.
        fw[0] = 32'h00500013;
        fw[1] = 32'h00A00093;
        send_frame(2, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("badcs_error", {31'd0, bus.error}, 32'd1);
        check("badcs_hold", {31'd0, bus.cpu_hold}, 32'd1);

        // Length bounds.
        send_frame(0, 1'b0, 1'b0, 1'b0);
        idle(2);
        send_frame(17, 1'b0, 1'b0, 1'b0);
        idle(2);
        randomize_words();
        send_frame(16, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("full_done", {31'd0, bus.done}, 32'd1);

        // Timeout after three data bytes, then restart.
        randomize_words();
        send_byte(SYNC_BYTE, 1'b0);
        send_byte(8'd2, 1'b0);
        for (int j = 0; j < 3; j++) send_byte(fw[0][8*j +: 8], 1'b0);
        o.done = 1'b0; o.error = 1'b1; o.by_byte = 1'b0;
        out_q.push_back(o);
        idle(TMO + 8);
        check("data_timeout_error", {31'd0, bus.error}, 32'd1);
        check("data_timeout_hold", {31'd0, bus.cpu_hold}, 32'd1);
        send_byte(SYNC_BYTE, 1'b0);
        check("restart_clears_error", {31'd0, bus.error}, 32'd0);
        randomize_words();
        send_frame(3, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("restart_done", {31'd0, bus.done}, 32'd1);

        // Longest legal gap inside a frame must not time out.
        randomize_words();
        send_byte(SYNC_BYTE, 1'b0);
        send_byte(8'd1, 1'b0);
        send_byte(fw[0][7:0], 1'b0);
        send_byte(fw[0][15:8], 1'b0);
        idle(TMO - 1);
        send_byte(fw[0][23:16], 1'b0);
        exp_q.push_back({32'd0, fw[0]});
        send_byte(fw[0][31:24], 1'b0);
        o.done = 1'b1; o.error = 1'b0; o.by_byte = 1'b1;
        out_q.push_back(o);
        send_byte(fw[0][7:0] ^ fw[0][15:8] ^ fw[0][23:16] ^ fw[0][31:24], 1'b0);
        idle(2);
        check("max_gap_done", {31'd0, bus.done}, 32'd1);

        // Reset after six data bytes: one write issued, the rest abandoned.
        randomize_words();
        send_byte(SYNC_BYTE, 1'b0);
        send_byte(8'd2, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j == 3) exp_q.push_back({32'd0, fw[0]});
            send_byte(fw[0][8*j +: 8], 1'b0);
        end
        send_byte(fw[1][7:0], 1'b0);
        send_byte(fw[1][15:8], 1'b0);
        idle(1);
        rst = 1'b0;
        idle(2);
        check_reset_outputs("midreset");
        rst = 1'b1;
        idle(1);
        randomize_words();
        send_frame(2, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Random frames with junk between them.
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == SYNC_BYTE) junk = 8'h00;
                send_byte(junk, 1'b1);
            end
            randomize_words();
            n = $urandom_range(1, 16);
            if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
            send_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 1'b0);
            idle($urandom_range(0, 3));
        end

        idle(10);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        check("outcomes_outstanding", 32'(out_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
